mem_arbiter: RTL and testbench

// Shares the single 128-bit memory port between the instruction cache and the data cache.

---
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port between the I-cache and the D-cache,
// granting one requester at a time and returning ready/rdata to the granted side only.
module mem_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [DATA_W-1:0] ic_wdata,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d, guard_i_q, guard_i_d, guard_d_q, guard_d_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic req_i, req_d, grant_i, grant_d, done;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      guard_i_q   <= 1'b0;
      guard_d_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      guard_i_q   <= guard_i_d;
      guard_d_q   <= guard_d_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The guard hides a requester for the one cycle its registered request takes to drop.
  always_comb begin
    req_i       = (ic_read | ic_write) & ~guard_i_q;
    req_d       = (dc_read | dc_write) & ~guard_d_q;
    grant_d     = (state_q == IDLE) && req_d && (!req_i || (ARB_MODE != 0) || !last_d_q);
    grant_i     = (state_q == IDLE) && req_i && !grant_d;
    done        = ic_ready | dc_ready;
    state_d     = grant_d ? BUSY_D : grant_i ? BUSY_I : done ? IDLE : state_q;
    last_d_d    = dc_ready ? 1'b1 : ic_ready ? 1'b0 : last_d_q;
    guard_i_d   = ic_ready;
    guard_d_d   = dc_ready;
    mem_read_d  = grant_d ? dc_read : grant_i ? ic_read : done ? 1'b0 : mem_read_q;
    mem_write_d = grant_d ? dc_write : grant_i ? ic_write : done ? 1'b0 : mem_write_q;
    mem_addr_d  = grant_d ? dc_addr : grant_i ? ic_addr : mem_addr_q;
    mem_wdata_d = grant_d ? dc_wdata : grant_i ? ic_wdata : mem_wdata_q;
  end

  always_comb begin
    ic_ready  = (state_q == BUSY_I) && mem_ready;
    dc_ready  = (state_q == BUSY_D) && mem_ready;
    ic_rdata  = ic_ready ? mem_rdata : '0;
    dc_rdata  = dc_ready ? mem_rdata : '0;
    mem_read  = mem_read_q;
    mem_write = mem_write_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin instance u0 checked through a bus/ready scoreboard,
// fixed-priority instance u1 checked cycle by cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [AW-1:0] M1_DA = 28'h0000D00;
  localparam logic [3:0] M1_EXP [7] = '{4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b1001};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ic_read [2], ic_write [2], dc_read [2], dc_write [2];
  logic ic_ready [2], dc_ready [2], mem_read [2], mem_write [2], mem_ready [2];
  logic [AW-1:0] ic_addr [2], dc_addr [2], mem_addr [2];
  logic [DW-1:0] ic_wdata [2], dc_wdata [2], ic_rdata [2], dc_rdata [2], mem_wdata [2], mem_rdata [2];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit auto_en [2];
  int lat [2];
  int cnt [2];

  typedef struct packed {
    logic rd;
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mreq_t;
  mreq_t mq[$];
  logic [DW-1:0] exp_i[$], exp_d[$];
  logic [DW-1:0] exp_v;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) u0 (
    .clk(clk), .proc_reset_n(rst_n),
    .ic_read(ic_read[0]), .ic_write(ic_write[0]), .ic_addr(ic_addr[0]), .ic_wdata(ic_wdata[0]),
    .ic_rdata(ic_rdata[0]), .ic_ready(ic_ready[0]),
    .dc_read(dc_read[0]), .dc_write(dc_write[0]), .dc_addr(dc_addr[0]), .dc_wdata(dc_wdata[0]),
    .dc_rdata(dc_rdata[0]), .dc_ready(dc_ready[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) u1 (
    .clk(clk), .proc_reset_n(rst_n),
    .ic_read(ic_read[1]), .ic_write(ic_write[1]), .ic_addr(ic_addr[1]), .ic_wdata(ic_wdata[1]),
    .ic_rdata(ic_rdata[1]), .ic_ready(ic_ready[1]),
    .dc_read(dc_read[1]), .dc_write(dc_write[1]), .dc_addr(dc_addr[1]), .dc_wdata(dc_wdata[1]),
    .dc_rdata(dc_rdata[1]), .dc_ready(dc_ready[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1])
  );

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return (a == 28'h0000010) ? {16{8'hA5}} : {4{4'h5, a}};
  endfunction

  always @(posedge clk) cyc++;

  // Memory model: answers a held strobe after lat[g] cycles with data derived from the address.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    always @(posedge clk) begin
      #2;
      if (auto_en[g]) begin
        if (mem_read[g] || mem_write[g]) begin
          cnt[g] = cnt[g] + 1;
          mem_ready[g] = (cnt[g] == lat[g]);
          mem_rdata[g] = mem_model(mem_addr[g]);
        end else begin
          cnt[g] = 0;
          mem_ready[g] = 1'b0;
          mem_rdata[g] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read[0] || mem_write[0]) begin
      checks++;
      if (mq.size() == 0)
        $display("FAIL mem_bus: unexpected strobe rd=%b wr=%b addr=%h", mem_read[0], mem_write[0], mem_addr[0]);
      else if ({mem_read[0], mem_write[0], mem_addr[0], mem_wdata[0]} !== mq[0])
        $display("FAIL mem_bus: got rd=%b wr=%b addr=%h wdata=%h, expected %h", mem_read[0], mem_write[0],
                 mem_addr[0], mem_wdata[0], mq[0]);
      else passed++;
      if (mem_ready[0] && mq.size() != 0) void'(mq.pop_front());
    end
    if (ic_ready[0]) begin
      checks++;
      if (exp_i.size() == 0) $display("FAIL ic_ready: unexpected pulse, rdata=%h", ic_rdata[0]);
      else begin
        exp_v = exp_i.pop_front();
        if (ic_rdata[0] !== exp_v || dc_ready[0] !== 1'b0 || dc_rdata[0] !== '0)
          $display("FAIL ic_ready: got rdata=%h dc_ready=%b dc_rdata=%h, expected rdata=%h with D side idle",
                   ic_rdata[0], dc_ready[0], dc_rdata[0], exp_v);
        else passed++;
      end
    end
    if (dc_ready[0]) begin
      checks++;
      if (exp_d.size() == 0) $display("FAIL dc_ready: unexpected pulse, rdata=%h", dc_rdata[0]);
      else begin
        exp_v = exp_d.pop_front();
        if (dc_rdata[0] !== exp_v || ic_ready[0] !== 1'b0 || ic_rdata[0] !== '0)
          $display("FAIL dc_ready: got rdata=%h ic_ready=%b ic_rdata=%h, expected rdata=%h with I side idle",
                   dc_rdata[0], ic_ready[0], ic_rdata[0], exp_v);
        else passed++;
      end
    end
  end

  task automatic request(input bit d, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] w, output int rdy_cyc);
    bit got;
    got = 1'b0;
    rdy_cyc = -1;
    @(posedge clk); #1;
    if (d) begin dc_read[0] = rd; dc_write[0] = wr; dc_addr[0] = a; dc_wdata[0] = w; end
    else begin ic_read[0] = rd; ic_write[0] = wr; ic_addr[0] = a; ic_wdata[0] = w; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = d ? dc_ready[0] : ic_ready[0];
    end
    rdy_cyc = cyc;
    checks++;
    if (!got) $display("FAIL ready_timeout: side=%0d saw no ready within 100 cycles, required a pulse", d);
    else passed++;
    @(posedge clk);
    @(posedge clk); #1;
    if (d) begin dc_read[0] = 1'b0; dc_write[0] = 1'b0; end
    else begin ic_read[0] = 1'b0; ic_write[0] = 1'b0; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_ready[0] = 1'b1;
    mem_rdata[0] = '1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({mem_read[u], mem_write[u], mem_addr[u], mem_wdata[u], ic_ready[u], dc_ready[u], ic_rdata[u], dc_rdata[u]} !== '0)
        $display("FAIL reset_state u%0d: rd=%b wr=%b addr=%h ic_rdy=%b dc_rdy=%b ic_rdata=%h, required all zero",
                 u, mem_read[u], mem_write[u], mem_addr[u], ic_ready[u], dc_ready[u], ic_rdata[u]);
      else passed++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      mem_ready[0] = (c == 4);
      mem_rdata[0] = {16{8'hA5}};
      @(negedge clk);
      checks++;
      if ({mem_read[0], mem_write[0], ic_ready[0], dc_ready[0]} !== 4'b0 || ic_rdata[0] !== '0)
        $display("FAIL idle_after_reset c%0d: rd=%b wr=%b ic_rdy=%b dc_rdy=%b, required 0", c,
                 mem_read[0], mem_write[0], ic_ready[0], dc_ready[0]);
      else passed++;
    end
    mem_ready[0] = 1'b0;
    auto_en[0] = 1'b1;
    auto_en[1] = 1'b1;
  endtask

  task automatic test_single_read;
    logic [DW-1:0] w;
    w = {4{32'h1111_2222}};
    lat[0] = 4;
    mq.push_back({1'b1, 1'b0, 28'h0000010, w});
    exp_i.push_back({16{8'hA5}});
    @(posedge clk); #1;
    ic_read[0] = 1'b1; ic_addr[0] = 28'h0000010; ic_wdata[0] = w;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b0) $display("FAIL read_c0: mem_read=%b, required 0", mem_read[0]);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_read[0], mem_addr[0]} !== {1'b1, 28'h0000010})
        $display("FAIL read_c%0d: mem_read=%b addr=%h, required 1 / 0000010", k, mem_read[0], mem_addr[0]);
      else passed++;
    end
    checks++;
    if (ic_ready[0] !== 1'b1 || ic_rdata[0] !== {16{8'hA5}} || dc_ready[0] !== 1'b0)
      $display("FAIL read_ready: ic_ready=%b ic_rdata=%h dc_ready=%b, required 1/A5..A5/0",
               ic_ready[0], ic_rdata[0], dc_ready[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b0 || ic_ready[0] !== 1'b0)
      $display("FAIL read_c5: mem_read=%b ic_ready=%b, required 0/0", mem_read[0], ic_ready[0]);
    else passed++;
    @(posedge clk); #1;
    ic_read[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b0) $display("FAIL read_guard: mem_read=%b after completion, required 0", mem_read[0]);
    else passed++;
  endtask

  task automatic test_tie_rr;
    int ri, rd;
    lat[0] = 2;
    mq.push_back({1'b0, 1'b1, 28'h0ABCDE0, {4{32'hDEAD_BEEF}}});
    mq.push_back({1'b1, 1'b0, 28'h0000200, 128'h0});
    exp_d.push_back(mem_model(28'h0ABCDE0));
    exp_i.push_back(mem_model(28'h0000200));
    fork
      request(1'b1, 1'b0, 1'b1, 28'h0ABCDE0, {4{32'hDEAD_BEEF}}, rd);
      request(1'b0, 1'b1, 1'b0, 28'h0000200, 128'h0, ri);
    join
    checks++;
    if (ri - rd != 3) $display("FAIL tie_d_first_gap: I ready %0d cycles after D ready, required 3", ri - rd);
    else passed++;
    mq.push_back({1'b1, 1'b0, 28'h0000300, 128'h7});
    exp_d.push_back(mem_model(28'h0000300));
    request(1'b1, 1'b1, 1'b0, 28'h0000300, 128'h7, rd);
    mq.push_back({1'b0, 1'b1, 28'h0000400, {2{64'h0123_4567_89AB_CDEF}}});
    mq.push_back({1'b1, 1'b0, 28'h0000500, 128'h0});
    exp_i.push_back(mem_model(28'h0000400));
    exp_d.push_back(mem_model(28'h0000500));
    fork
      request(1'b1, 1'b1, 1'b0, 28'h0000500, 128'h0, rd);
      request(1'b0, 1'b0, 1'b1, 28'h0000400, {2{64'h0123_4567_89AB_CDEF}}, ri);
    join
    checks++;
    if (rd - ri != 3) $display("FAIL tie_i_next_gap: D ready %0d cycles after I ready, required 3", rd - ri);
    else passed++;
  endtask

  task automatic test_dc_drop;
    lat[0] = 4;
    mq.push_back({1'b1, 1'b0, 28'h0000C40, {4{32'hCAFE_F00D}}});
    exp_d.push_back(mem_model(28'h0000C40));
    @(posedge clk); #1;
    dc_read[0] = 1'b1; dc_addr[0] = 28'h0000C40; dc_wdata[0] = {4{32'hCAFE_F00D}};
    @(posedge clk); #1;
    dc_read[0] = 1'b0; dc_addr[0] = 28'h0000FFF;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      else @(negedge clk);
      checks++;
      if (mem_read[0] !== 1'b1) $display("FAIL drop_c%0d: mem_read=%b, required 1", k, mem_read[0]);
      else passed++;
    end
    checks++;
    if (dc_ready[0] !== 1'b1 || dc_rdata[0] !== mem_model(28'h0000C40))
      $display("FAIL drop_ready: dc_ready=%b dc_rdata=%h, required 1/%h", dc_ready[0], dc_rdata[0],
               mem_model(28'h0000C40));
    else passed++;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b0) $display("FAIL drop_end: mem_read=%b, required 0", mem_read[0]);
    else passed++;
  endtask

  task automatic test_reset_abort;
    auto_en[0] = 1'b0;
    mem_ready[0] = 1'b0;
    mq.push_back({1'b1, 1'b0, 28'h0000A00, 128'h0});
    @(posedge clk); #1;
    ic_read[0] = 1'b1; ic_addr[0] = 28'h0000A00; ic_wdata[0] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b1) $display("FAIL abort_busy: mem_read=%b, required 1", mem_read[0]);
    else passed++;
    #1 rst_n = 1'b0;
    ic_read[0] = 1'b0;
    #1;
    checks++;
    if (mem_read[0] !== 1'b0) $display("FAIL abort_async: mem_read=%b during reset, required 0", mem_read[0]);
    else passed++;
    mq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_ready[0] = 1'b1;
    mem_rdata[0] = {16{8'hA5}};
    @(negedge clk);
    checks++;
    if (ic_ready[0] !== 1'b0 || dc_ready[0] !== 1'b0 || mem_read[0] !== 1'b0)
      $display("FAIL abort_late_ready: ic_ready=%b dc_ready=%b mem_read=%b, required 0", ic_ready[0],
               dc_ready[0], mem_read[0]);
    else passed++;
    @(posedge clk); #1;
    mem_ready[0] = 1'b0;
    auto_en[0] = 1'b1;
  endtask

  task automatic test_fixed_priority;
    logic [3:0] obs;
    lat[1] = 1;
    dc_addr[1] = M1_DA;
    ic_addr[1] = 28'h0000E00;
    ic_wdata[1] = 128'h55;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) dc_read[1] = 1'b1;
      if (c == 3) ic_write[1] = 1'b1;
      if (c == 7) begin dc_read[1] = 1'b0; ic_write[1] = 1'b0; end
      @(negedge clk);
      obs = {ic_ready[1], dc_ready[1], (mem_read[1] || mem_write[1]) ? ((mem_addr[1] == M1_DA) ? 2'd2 : 2'd1) : 2'd0};
      checks++;
      if (obs !== ((c < 7) ? M1_EXP[c] : 4'b0000))
        $display("FAIL prio_c%0d: {ic_rdy,dc_rdy,owner}=%b, required %b", c, obs, (c < 7) ? M1_EXP[c] : 4'b0000);
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      ic_read[u] = 1'b0; ic_write[u] = 1'b0; dc_read[u] = 1'b0; dc_write[u] = 1'b0;
      ic_addr[u] = '0; dc_addr[u] = '0; ic_wdata[u] = '0; dc_wdata[u] = '0;
      mem_ready[u] = 1'b0; mem_rdata[u] = '0;
      auto_en[u] = 1'b0; lat[u] = 1; cnt[u] = 0;
    end
    test_reset();
    test_single_read();
    test_tie_rr();
    test_dc_drop();
    test_reset_abort();
    test_fixed_priority();
    repeat (2) @(negedge clk);
    checks++;
    if (mq.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0)
      $display("FAIL scoreboard_drain: mem=%0d ic=%0d dc=%0d left, required 0", mq.size(), exp_i.size(), exp_d.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
